// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control outputs of the stopwatch sequencer.
// The lap_btn signal exists only when STOPWATCH_LAP_EN is defined.
interface stopwatch_ctrl_if;
    logic       start_btn;
    logic       stop_btn;
    logic       clr_btn;
`ifdef STOPWATCH_LAP_EN
    logic       lap_btn;
`endif
    logic       tick_en;
    logic       cnt_clr;
    logic       running;
    logic       disp_freeze;
    logic [1:0] state;

`ifdef STOPWATCH_LAP_EN
    modport master (output start_btn, stop_btn, clr_btn, lap_btn,
                    input  tick_en, cnt_clr, running, disp_freeze, state);
    modport slave  (input  start_btn, stop_btn, clr_btn, lap_btn,
                    output tick_en, cnt_clr, running, disp_freeze, state);
`else
    modport master (output start_btn, stop_btn, clr_btn,
                    input  tick_en, cnt_clr, running, disp_freeze, state);
    modport slave  (input  start_btn, stop_btn, clr_btn,
                    output tick_en, cnt_clr, running, disp_freeze, state);
`endif
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button sync/debounce/edge detect, run/pause/clear FSM, gated prescaler.
// Optional lap/display-freeze state enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int DIV       = 50000000,
    parameter int DB_CYCLES = 1000000,
    parameter int PW        = 26,
    parameter int DW        = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
`ifdef STOPWATCH_LAP_EN
        S_LAP   = 2'b11,
`endif
        S_PAUSE = 2'b10
    } state_t;

`ifdef STOPWATCH_LAP_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic [NB-1:0] w_raw;
    logic [NB-1:0] r_s1, r_s2, r_db, r_db_q, r_press;
    logic [DW-1:0] r_dbcnt [NB];

`ifdef STOPWATCH_LAP_EN
    assign w_raw = {bus.lap_btn, bus.clr_btn, bus.stop_btn, bus.start_btn};
`else
    assign w_raw = {bus.clr_btn, bus.stop_btn, bus.start_btn};
`endif

    // Press is registered so the FSM sees a clean single-cycle strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_db    <= '0;
            r_db_q  <= '0;
            r_press <= '0;
            for (int i = 0; i < NB; i++) r_dbcnt[i] <= '0;
        end else begin
            r_s1    <= w_raw;
            r_s2    <= r_s1;
            r_db_q  <= r_db;
            r_press <= r_db & ~r_db_q;
            for (int i = 0; i < NB; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_dbcnt[i] <= '0;
                end else if (r_dbcnt[i] == DW'(DB_CYCLES - 1)) begin
                    r_db[i]    <= r_s2[i];
                    r_dbcnt[i] <= '0;
                end else begin
                    r_dbcnt[i] <= r_dbcnt[i] + DW'(1);
                end
            end
        end
    end

    logic w_start, w_stop, w_clr;
    assign w_start = r_press[0];
    assign w_stop  = r_press[1];
    assign w_clr   = r_press[2];
`ifdef STOPWATCH_LAP_EN
    logic w_lap;
    assign w_lap   = r_press[3];
`endif

    logic [1:0]    r_state;
    logic [PW-1:0] r_presc;
    logic          r_tick, r_cnt_clr, r_running, r_freeze;
    state_t        w_state_nxt;
    logic          w_clr_nxt, w_counting, w_wrap;

    always_comb begin
        w_state_nxt = state_t'(r_state);
        w_clr_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_clr)        w_clr_nxt   = 1'b1;
                else if (w_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_clr) begin
                    w_state_nxt = S_IDLE;
                    w_clr_nxt   = 1'b1;
                end else if (w_stop) begin
                    w_state_nxt = S_PAUSE;
                end
`ifdef STOPWATCH_LAP_EN
                else if (w_lap) begin
                    w_state_nxt = S_LAP;
                end
`endif
            end
            S_PAUSE: begin
                if (w_clr) begin
                    w_state_nxt = S_IDLE;
                    w_clr_nxt   = 1'b1;
                end else if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
`ifdef STOPWATCH_LAP_EN
            S_LAP: begin
                if (w_clr) begin
                    w_state_nxt = S_IDLE;
                    w_clr_nxt   = 1'b1;
                end else if (w_stop) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_lap) begin
                    w_state_nxt = S_RUN;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
`else
    assign w_counting = (r_state == S_RUN);
`endif
    assign w_wrap = w_counting && (r_presc == PW'(DIV - 1));

    // Tick is decided by the current state; a clear in the same cycle suppresses it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_running <= 1'b0;
            r_freeze  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt_clr <= w_clr_nxt;
            r_tick    <= w_wrap && !w_clr_nxt;
`ifdef STOPWATCH_LAP_EN
            r_running <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
            r_freeze  <= (w_state_nxt == S_LAP);
`else
            r_running <= (w_state_nxt == S_RUN);
            r_freeze  <= 1'b0;
`endif
            if (w_clr_nxt || w_wrap) r_presc <= '0;
            else if (w_counting)     r_presc <= r_presc + PW'(1);
        end
    end

    assign bus.tick_en     = r_tick;
    assign bus.cnt_clr     = r_cnt_clr;
    assign bus.running     = r_running;
    assign bus.disp_freeze = r_freeze;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10, DB_CYCLES=4.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   k = 0;
    int   n_clr;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.DIV(10), .DB_CYCLES(4), .PW(4), .DW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sw_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps while counting; a tick is due whenever k reaches a multiple of 10.
    task automatic step_run(input int n);
        repeat (n) begin
            step();
            k++;
            chk("tick_run", 32'(sw_if.tick_en), 32'(k % 10 == 0));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw_if.start_btn = 1'b1;
        sw_if.stop_btn  = 1'b1;
        sw_if.clr_btn   = 1'b1;
`ifdef STOPWATCH_LAP_EN
        sw_if.lap_btn   = 1'b1;
`endif
        step(); step(); step();
        chk("rst_tick",    32'(sw_if.tick_en),     32'd0);
        chk("rst_cnt_clr", 32'(sw_if.cnt_clr),     32'd0);
        chk("rst_running", 32'(sw_if.running),     32'd0);
        chk("rst_freeze",  32'(sw_if.disp_freeze), 32'd0);
        chk("rst_state",   32'(sw_if.state),       32'd0);

        // Start held through reset release: press appears 7 clocks after first sample
        rst_n = 1'b1;
        sw_if.stop_btn = 1'b0;
        sw_if.clr_btn  = 1'b0;
`ifdef STOPWATCH_LAP_EN
        sw_if.lap_btn  = 1'b0;
`endif
        repeat (7) step();
        chk("start_early", 32'(sw_if.running), 32'd0);
        step();
        chk("start_run",   32'(sw_if.running), 32'd1);
        chk("start_state", 32'(sw_if.state),   32'd1);
        sw_if.start_btn = 1'b0;
        k = 0;
        step_run(35);

        // 3-clock stop glitch must be rejected
        sw_if.stop_btn = 1'b1;
        step_run(3);
        sw_if.stop_btn = 1'b0;
        step_run(6);
        chk("glitch_state", 32'(sw_if.state), 32'd1);

        // Stop lands so the held prescaler value is 6
        step_run(4);
        sw_if.stop_btn = 1'b1;
        step_run(7);
        chk("stop_early", 32'(sw_if.state), 32'd1);
        step();
        chk("pause_state",   32'(sw_if.state),   32'd2);
        chk("pause_running", 32'(sw_if.running), 32'd0);
        chk("pause_tick",    32'(sw_if.tick_en), 32'd0);
        sw_if.stop_btn = 1'b0;
        repeat (50) begin
            step();
            chk("pause_hold_tick",  32'(sw_if.tick_en), 32'd0);
            chk("pause_hold_state", 32'(sw_if.state),   32'd2);
        end

        // Resume: first tick 4 clocks after re-entering RUN
        sw_if.start_btn = 1'b1;
        repeat (7) step();
        chk("resume_early", 32'(sw_if.state), 32'd2);
        step();
        chk("resume_state", 32'(sw_if.state), 32'd1);
        sw_if.start_btn = 1'b0;
        k = 6;
        step_run(4);

        // Stop and clr together exactly when the wrap is due
        step_run(2);
        sw_if.stop_btn = 1'b1;
        sw_if.clr_btn  = 1'b1;
        step_run(7);
        step();
        chk("coin_state",   32'(sw_if.state),   32'd0);
        chk("coin_cnt_clr", 32'(sw_if.cnt_clr), 32'd1);
        chk("coin_tick",    32'(sw_if.tick_en), 32'd0);
        chk("coin_running", 32'(sw_if.running), 32'd0);
        sw_if.stop_btn = 1'b0;
        sw_if.clr_btn  = 1'b0;
        step();
        chk("coin_clr_width", 32'(sw_if.cnt_clr), 32'd0);
        chk("coin_tick_late", 32'(sw_if.tick_en), 32'd0);
        repeat (10) step();

        // Held clr in IDLE: exactly one strobe
        sw_if.clr_btn = 1'b1;
        n_clr = 0;
        repeat (30) begin
            step();
            n_clr += int'(sw_if.cnt_clr);
        end
        chk("held_clr_pulses", 32'(n_clr),        32'd1);
        chk("held_clr_state",  32'(sw_if.state),  32'd0);
        sw_if.clr_btn = 1'b0;
        repeat (10) step();

        // Restart from IDLE: prescaler was cleared, so first tick is 10 clocks in
        sw_if.start_btn = 1'b1;
        repeat (7) step();
        chk("restart_early", 32'(sw_if.state), 32'd0);
        step();
        chk("restart_state", 32'(sw_if.state), 32'd1);
        sw_if.start_btn = 1'b0;
        k = 0;
        step_run(29);

        // Reset with a wrap due: no tick may escape
        rst_n = 1'b0;
        step();
        chk("abort_tick",    32'(sw_if.tick_en), 32'd0);
        chk("abort_state",   32'(sw_if.state),   32'd0);
        chk("abort_running", 32'(sw_if.running), 32'd0);
        chk("abort_cnt_clr", 32'(sw_if.cnt_clr), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_tick",  32'(sw_if.tick_en), 32'd0);
        chk("post_rst_state", 32'(sw_if.state),   32'd0);

`ifdef STOPWATCH_LAP_EN
        sw_if.start_btn = 1'b1;
        repeat (8) step();
        chk("lap_run_state", 32'(sw_if.state), 32'd1);
        sw_if.start_btn = 1'b0;
        k = 0;
        step_run(2);
        sw_if.lap_btn = 1'b1;
        step_run(8);
        chk("lap_state",   32'(sw_if.state),       32'd3);
        chk("lap_freeze",  32'(sw_if.disp_freeze), 32'd1);
        chk("lap_running", 32'(sw_if.running),     32'd1);
        sw_if.lap_btn = 1'b0;
        step_run(10);
        sw_if.lap_btn = 1'b1;
        step_run(8);
        chk("unlap_state",  32'(sw_if.state),       32'd1);
        chk("unlap_freeze", 32'(sw_if.disp_freeze), 32'd0);
        sw_if.lap_btn = 1'b0;
        step_run(10);
`else
        force dut.r_state = 2'b11;
        #1;
        release dut.r_state;
        step();
        chk("illegal_state",   32'(sw_if.state),       32'd0);
        chk("illegal_running", 32'(sw_if.running),     32'd0);
        chk("freeze_tied",     32'(sw_if.disp_freeze), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
